// File: rtl/osd_wb_mam_slave.sv
// Wishbone classic-cycle slave that forwards each single-beat access as one
// MAM request followed by one write-data or read-data beat.
module osd_wb_mam_slave #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  output logic                    ack_o,
  output logic                    err_o,
  output logic [DATA_WIDTH-1:0]   dat_o,

  output logic                    req_valid,
  input  logic                    req_ready,
  output logic                    req_rw,
  output logic [ADDR_WIDTH-1:0]   req_addr,
  output logic                    req_burst,
  output logic [13:0]             req_beats,

  output logic                    write_valid,
  input  logic                    write_ready,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic [DATA_WIDTH/8-1:0] write_strb,

  input  logic                    read_valid,
  output logic                    read_ready,
  input  logic [DATA_WIDTH-1:0]   read_data
);

  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WDATA = 3'd2,
    RDATA = 3'd3,
    ACK   = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t                state_q, state_n;
  logic [CW-1:0]         cnt_q, cnt_n;
  logic                  capture;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [SW-1:0]         sel_q;

  assign req_rw     = we_q;
  assign req_addr   = adr_q;
  assign write_data = dat_q;
  assign write_strb = sel_q;
  assign req_burst  = 1'b0;
  assign req_beats  = 14'd1;

  // Next-state: req_ready beats abort, abort beats timeout
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (cyc_i && stb_i) begin
          capture = 1'b1;
          cnt_n   = '0;
          state_n = REQ;
        end
      end
      REQ: begin
        if (req_ready) begin
          state_n = we_q ? WDATA : RDATA;
        end else if (!cyc_i) begin
          state_n = IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_n = ERR;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      WDATA:   if (write_ready) state_n = ACK;
      RDATA:   if (read_valid)  state_n = ACK;
      ACK:     state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, captured access and registered output decode
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      dat_o       <= '0;
      req_valid   <= 1'b0;
      write_valid <= 1'b0;
      read_ready  <= 1'b0;
      ack_o       <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      if (capture) begin
        we_q  <= we_i;
        adr_q <= adr_i;
        dat_q <= dat_i;
        sel_q <= sel_i;
      end
      if ((state_q == RDATA) && read_valid) dat_o <= read_data;
      req_valid   <= (state_n == REQ);
      write_valid <= (state_n == WDATA);
      read_ready  <= (state_n == RDATA);
      // Termination is dropped if the master has already abandoned the cycle
      ack_o       <= (state_n == ACK) && cyc_i;
      err_o       <= (state_n == ERR) && cyc_i;
    end
  end

endmodule

// File: tb/tb_osd_wb_mam_slave.sv
// Directed bench for osd_wb_mam_slave: writes, stalled reads, timeout,
// abort/suppression and reset during a transaction.
module tb_osd_wb_mam_slave;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          cyc_i, stb_i, we_i;
  logic [AW-1:0] adr_i;
  logic [DW-1:0] dat_i;
  logic [1:0]    sel_i;
  logic          ack_o, err_o;
  logic [DW-1:0] dat_o;
  logic          req_valid, req_ready, req_rw, req_burst;
  logic [AW-1:0] req_addr;
  logic [13:0]   req_beats;
  logic          write_valid, write_ready;
  logic [DW-1:0] write_data;
  logic [1:0]    write_strb;
  logic          read_valid, read_ready;
  logic [DW-1:0] read_data;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  osd_wb_mam_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i),
    .dat_i(dat_i), .sel_i(sel_i), .ack_o(ack_o), .err_o(err_o), .dat_o(dat_o),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_burst(req_burst), .req_beats(req_beats),
    .write_valid(write_valid), .write_ready(write_ready),
    .write_data(write_data), .write_strb(write_strb),
    .read_valid(read_valid), .read_ready(read_ready), .read_data(read_data)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wb_start(input logic we, input logic [AW-1:0] adr,
                          input logic [DW-1:0] dat, input logic [1:0] sel);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
  endtask

  task automatic wb_drop();
    cyc_i = 1'b0; stb_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    adr_i = '0; dat_i = '0; sel_i = '0;
    req_ready = 1'b0; write_ready = 1'b0; read_valid = 1'b0; read_data = '0;
    tick(); tick();
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_wvalid", 32'(write_valid), 32'd0);
    chk("rst_rready", 32'(read_ready), 32'd0);
    chk("rst_dat_o", 32'(dat_o), 32'd0);
    chk("rst_req_addr", req_addr, 32'd0);
    rst_ni = 1'b1;
    tick();

    // zero-wait write
    req_ready = 1'b1; write_ready = 1'b1;
    wb_start(1'b1, 32'h100, 16'hBEEF, 2'b11);
    tick();
    chk("w0_req_valid", 32'(req_valid), 32'd1);
    chk("w0_req_rw", 32'(req_rw), 32'd1);
    chk("w0_req_addr", req_addr, 32'h100);
    chk("w0_ack_c1", 32'(ack_o), 32'd0);
    tick();
    chk("w0_wvalid", 32'(write_valid), 32'd1);
    chk("w0_wdata", 32'(write_data), 32'hBEEF);
    chk("w0_wstrb", 32'(write_strb), 32'h3);
    chk("w0_ack_c2", 32'(ack_o), 32'd0);
    tick();
    chk("w0_ack_c3", 32'(ack_o), 32'd1);
    chk("w0_err_c3", 32'(err_o), 32'd0);
    chk("w0_wvalid_c3", 32'(write_valid), 32'd0);
    wb_drop();
    tick();
    chk("w0_ack_c4", 32'(ack_o), 32'd0);
    chk("w0_idle", 32'(req_valid), 32'd0);

    // read with request and data stalls
    req_ready = 1'b0; write_ready = 1'b0;
    wb_start(1'b0, 32'h200, 16'h0, 2'b11);
    tick();
    chk("r1_req_valid_c1", 32'(req_valid), 32'd1);
    chk("r1_req_rw", 32'(req_rw), 32'd0);
    chk("r1_req_addr", req_addr, 32'h200);
    tick(); tick();
    chk("r1_req_valid_c3", 32'(req_valid), 32'd1);
    chk("r1_rready_c3", 32'(read_ready), 32'd0);
    req_ready = 1'b1;
    tick();
    chk("r1_req_valid_c4", 32'(req_valid), 32'd0);
    chk("r1_rready_c4", 32'(read_ready), 32'd1);
    req_ready = 1'b0;
    tick(); tick(); tick();
    chk("r1_rready_c7", 32'(read_ready), 32'd1);
    chk("r1_ack_c7", 32'(ack_o), 32'd0);
    chk("r1_dat_o_c7", 32'(dat_o), 32'd0);
    read_valid = 1'b1; read_data = 16'h1234;
    tick();
    chk("r1_ack_c8", 32'(ack_o), 32'd1);
    chk("r1_dat_o_c8", 32'(dat_o), 32'h1234);
    chk("r1_rready_c8", 32'(read_ready), 32'd0);
    wb_drop(); read_valid = 1'b0; read_data = '0;
    tick();
    chk("r1_ack_c9", 32'(ack_o), 32'd0);
    chk("r1_dat_o_hold", 32'(dat_o), 32'h1234);

    // partial write
    req_ready = 1'b1; write_ready = 1'b1;
    wb_start(1'b1, 32'h300, 16'hA5A5, 2'b10);
    tick();
    chk("pw_burst", 32'(req_burst), 32'd0);
    chk("pw_beats", 32'(req_beats), 32'd1);
    tick();
    chk("pw_wstrb", 32'(write_strb), 32'h2);
    chk("pw_wdata", 32'(write_data), 32'hA5A5);
    chk("pw_beats_wdata", 32'(req_beats), 32'd1);
    tick();
    chk("pw_ack", 32'(ack_o), 32'd1);
    wb_drop();
    tick();

    // timeout with req_ready held low
    req_ready = 1'b0; write_ready = 1'b0;
    wb_start(1'b0, 32'h400, 16'h0, 2'b11);
    tick(); tick(); tick(); tick();
    chk("to_err_c4", 32'(err_o), 32'd0);
    chk("to_req_valid_c4", 32'(req_valid), 32'd1);
    tick();
    chk("to_err_c5", 32'(err_o), 32'd1);
    chk("to_ack_c5", 32'(ack_o), 32'd0);
    chk("to_req_valid_c5", 32'(req_valid), 32'd0);
    wb_drop();
    tick();
    chk("to_err_c6", 32'(err_o), 32'd0);
    req_ready = 1'b1; read_valid = 1'b1; read_data = 16'h5678;
    wb_start(1'b0, 32'h404, 16'h0, 2'b11);
    tick(); tick(); tick();
    chk("to_next_ack", 32'(ack_o), 32'd1);
    chk("to_next_err", 32'(err_o), 32'd0);
    chk("to_next_dat", 32'(dat_o), 32'h5678);
    wb_drop(); read_valid = 1'b0; read_data = '0;
    tick();

    // abort in REQ
    req_ready = 1'b0;
    wb_start(1'b1, 32'h500, 16'h7777, 2'b11);
    tick();
    chk("ab_req_valid_c1", 32'(req_valid), 32'd1);
    wb_drop();
    tick();
    chk("ab_req_valid_c2", 32'(req_valid), 32'd0);
    chk("ab_wvalid_c2", 32'(write_valid), 32'd0);
    req_ready = 1'b1; write_ready = 1'b1;
    tick();
    chk("ab_ack_c3", 32'(ack_o), 32'd0);
    chk("ab_wvalid_c3", 32'(write_valid), 32'd0);

    // cyc dropped during RDATA: handshake completes, ack suppressed
    write_ready = 1'b0; read_valid = 1'b0;
    wb_start(1'b0, 32'h600, 16'h0, 2'b11);
    tick(); tick();
    chk("sup_rready", 32'(read_ready), 32'd1);
    wb_drop(); read_valid = 1'b1; read_data = 16'h9ABC;
    tick();
    chk("sup_ack", 32'(ack_o), 32'd0);
    chk("sup_rready_done", 32'(read_ready), 32'd0);
    chk("sup_dat_o", 32'(dat_o), 32'h9ABC);
    read_valid = 1'b0; read_data = '0;
    tick();
    chk("sup_ack_next", 32'(ack_o), 32'd0);

    // reset during RDATA, then back-to-back writes
    wb_start(1'b0, 32'h700, 16'h0, 2'b11);
    tick(); tick();
    chk("rr_rready", 32'(read_ready), 32'd1);
    rst_ni = 1'b0; wb_drop();
    tick();
    chk("rr_rready_rst", 32'(read_ready), 32'd0);
    chk("rr_dat_o_rst", 32'(dat_o), 32'd0);
    chk("rr_req_addr_rst", req_addr, 32'd0);
    chk("rr_ack_rst", 32'(ack_o), 32'd0);
    rst_ni = 1'b1;
    tick();
    chk("rr_idle", 32'(req_valid), 32'd0);
    req_ready = 1'b1; write_ready = 1'b1;
    wb_start(1'b1, 32'h800, 16'h1111, 2'b11);
    tick(); tick(); tick();
    chk("bb_ack0", 32'(ack_o), 32'd1);
    wb_drop();
    tick();
    chk("bb_gap_ack", 32'(ack_o), 32'd0);
    chk("bb_gap_req", 32'(req_valid), 32'd0);
    wb_start(1'b1, 32'h804, 16'h2222, 2'b01);
    tick();
    chk("bb_req_addr", req_addr, 32'h804);
    tick();
    chk("bb_wdata", 32'(write_data), 32'h2222);
    chk("bb_wstrb", 32'(write_strb), 32'h1);
    tick();
    chk("bb_ack1", 32'(ack_o), 32'd1);
    wb_drop();
    tick();
    chk("bb_ack1_end", 32'(ack_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
